// File: rtl/rattlesnake_blk_wr_guard.sv
// rtl/rattlesnake_blk_wr_guard.sv - LIFO of protected addresses scanned against detected block-write ranges
// Optional feature macro: RATTLESNAKE_BLK_WR_GUARD_WRAP_EN (push when full overwrites the oldest entry)
module rattlesnake_blk_wr_guard #(
    parameter int DEPTH     = 8,
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sync_reset,
    input  logic                 blk_write_active,
    input  logic [ADDR_BITS-1:0] blk_wr_start,
    input  logic [ADDR_BITS-1:0] blk_wr_end,
    input  logic                 exception_handler_active,
    input  logic                 push_en,
    input  logic [ADDR_BITS-1:0] push_addr,
    input  logic                 pop_en,
    input  logic                 violation_ack,
    output logic                 violation,
    output logic [ADDR_BITS-1:0] violation_addr,
    output logic                 stack_empty,
    output logic                 stack_full,
    output logic                 overflow
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOLD} state_t;

    state_t               state, state_next;
    logic [ADDR_BITS-1:0] mem [DEPTH];
    logic [CW-1:0]        count;
    logic [IW-1:0]        idx, idx_next;
    logic [ADDR_BITS-1:0] rng_start, rng_end;
    logic                 rescan;
    logic                 prev_active;

    logic [IW-1:0]        top_idx, eff_idx;
    logic [ADDR_BITS-1:0] entry;
    logic                 entry_hit, end_changed, trigger;
    logic                 latch_rng, clr_rescan, set_hit;

    assign stack_empty = (count == '0);
    assign stack_full  = (count == CW'(DEPTH));

    assign top_idx     = IW'(count - CW'(1));
    // Pops during a scan can leave idx above the new top; clamp before compare.
    assign eff_idx     = ({1'b0, idx} >= count) ? top_idx : idx;
    assign entry       = mem[eff_idx];
    assign entry_hit   = (entry >= rng_start) && (entry < rng_end);
    assign end_changed = (blk_wr_end != rng_end);
    assign trigger     = blk_write_active && !exception_handler_active &&
                         ((blk_write_active && !prev_active) || end_changed || rescan);

    // LIFO count and sticky overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (sync_reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (push_en && pop_en && !stack_empty) begin
            count <= count;
        end else if (push_en) begin
            if (stack_full)
                overflow <= 1'b1;
            else
                count <= count + CW'(1);
        end else if (pop_en && !stack_empty) begin
            count <= count - CW'(1);
        end
    end

    // Storage needs no reset: count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!sync_reset) begin
            if (push_en && pop_en && !stack_empty) begin
                mem[top_idx] <= push_addr;
            end else if (push_en && !stack_full) begin
                mem[count[IW-1:0]] <= push_addr;
            end else if (push_en) begin
`ifdef RATTLESNAKE_BLK_WR_GUARD_WRAP_EN
                for (int i = 0; i < DEPTH - 1; i++)
                    mem[i] <= mem[i+1];
                mem[DEPTH-1] <= push_addr;
`endif
            end
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        latch_rng  = 1'b0;
        clr_rescan = 1'b0;
        set_hit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (trigger) begin
                    latch_rng  = 1'b1;
                    clr_rescan = 1'b1;
                    idx_next   = top_idx;
                    if (!stack_empty)
                        state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (exception_handler_active || !blk_write_active) begin
                    state_next = S_IDLE;
                end else if (end_changed) begin
                    latch_rng = 1'b1;
                    idx_next  = top_idx;
                    if (stack_empty)
                        state_next = S_IDLE;
                end else if (stack_empty) begin
                    state_next = S_IDLE;
                end else if (entry_hit) begin
                    set_hit    = 1'b1;
                    state_next = S_HOLD;
                end else if (eff_idx == '0) begin
                    state_next = S_IDLE;
                end else begin
                    idx_next = eff_idx - IW'(1);
                end
            end
            S_HOLD: begin
                if (violation_ack)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            idx            <= '0;
            rng_start      <= '0;
            rng_end        <= '0;
            rescan         <= 1'b0;
            prev_active    <= 1'b0;
            violation      <= 1'b0;
            violation_addr <= '0;
        end else if (sync_reset) begin
            state          <= S_IDLE;
            idx            <= '0;
            rng_start      <= '0;
            rng_end        <= '0;
            rescan         <= 1'b0;
            prev_active    <= 1'b0;
            violation      <= 1'b0;
            violation_addr <= '0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            prev_active <= blk_write_active;
            violation   <= (state_next == S_HOLD);
            if (latch_rng) begin
                rng_start <= blk_wr_start;
                rng_end   <= blk_wr_end;
            end
            if (set_hit)
                violation_addr <= entry;
            if (state == S_SCAN && push_en)
                rescan <= 1'b1;
            else if (clr_rescan)
                rescan <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rattlesnake_blk_wr_guard.sv
// tb/tb_rattlesnake_blk_wr_guard.sv - randomized scoreboard bench for rattlesnake_blk_wr_guard
module tb_rattlesnake_blk_wr_guard;

    localparam int DEPTH = 8;
    localparam int AB    = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sync_reset = 1'b0;
    logic          blk_write_active = 1'b0;
    logic [AB-1:0] blk_wr_start = '0;
    logic [AB-1:0] blk_wr_end = '0;
    logic          exception_handler_active = 1'b0;
    logic          push_en = 1'b0;
    logic [AB-1:0] push_addr = '0;
    logic          pop_en = 1'b0;
    logic          violation_ack = 1'b0;
    logic          violation;
    logic [AB-1:0] violation_addr;
    logic          stack_empty;
    logic          stack_full;
    logic          overflow;

    rattlesnake_blk_wr_guard #(.DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
        .blk_write_active(blk_write_active), .blk_wr_start(blk_wr_start),
        .blk_wr_end(blk_wr_end), .exception_handler_active(exception_handler_active),
        .push_en(push_en), .push_addr(push_addr), .pop_en(pop_en),
        .violation_ack(violation_ack), .violation(violation),
        .violation_addr(violation_addr), .stack_empty(stack_empty),
        .stack_full(stack_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: stack contents, bottom first
    logic [AB-1:0] mdl[$];
    int            exp_addr[$];
    int            exp_cyc[$];
    logic          v_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (violation && !v_prev) begin
            if (exp_addr.size() == 0) begin
                vectors++;
                errs++;
                $display("FAIL unexpected_violation: got addr %0h at cycle %0d, expected none", violation_addr, cyc);
            end else begin
                chk("violation_addr", int'(violation_addr), exp_addr.pop_front());
                chk("violation_cycle", cyc, exp_cyc.pop_front());
            end
        end
        v_prev = violation;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_push(input logic [AB-1:0] a);
        if (mdl.size() < DEPTH) begin
            mdl.push_back(a);
        end else begin
`ifdef RATTLESNAKE_BLK_WR_GUARD_WRAP_EN
            void'(mdl.pop_front());
            mdl.push_back(a);
`endif
        end
    endtask

    task automatic do_push(input logic [AB-1:0] a);
        push_en = 1'b1; push_addr = a;
        tick();
        push_en = 1'b0;
        m_push(a);
    endtask

    task automatic do_pop();
        pop_en = 1'b1;
        tick();
        pop_en = 1'b0;
        if (mdl.size() > 0) void'(mdl.pop_back());
    endtask

    task automatic do_sreset();
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        mdl.delete();
    endtask

    // Topmost entry inside [s,e) wins; returns -1 if none
    function automatic int find_hit(input logic [AB-1:0] s, input logic [AB-1:0] e);
        for (int k = mdl.size() - 1; k >= 0; k--)
            if (mdl[k] >= s && mdl[k] < e) return k;
        return -1;
    endfunction

    task automatic wait_ack();
        for (int i = 0; i < 2 * DEPTH + 6 && !violation; i++) tick();
        if (violation) begin
            violation_ack = 1'b1;
            tick();
            violation_ack = 1'b0;
            chk("ack_clears", int'(violation), 0);
        end
    endtask

    task automatic drain_check();
        chk("missing_violations", exp_addr.size(), 0);
        exp_addr.delete();
        exp_cyc.delete();
    endtask

    // mode 0: normal, 1: exception active from start, 2: exception raised mid-scan
    task automatic do_scan(input logic [AB-1:0] s, input logic [AB-1:0] e, input int mode);
        int k, c;
        blk_wr_start = s; blk_wr_end = e;
        if (mode == 1) exception_handler_active = 1'b1;
        blk_write_active = 1'b1;
        c = cyc;
        k = find_hit(s, e);
        if (mode == 0 && k >= 0) begin
            exp_addr.push_back(int'(mdl[k]));
            exp_cyc.push_back(c + 2 + (mdl.size() - 1 - k));
            wait_ack();
        end else begin
            if (mode == 2) begin
                repeat (3) tick();
                exception_handler_active = 1'b1;
            end
            repeat (DEPTH + 4) tick();
        end
        blk_write_active = 1'b0;
        tick();
        exception_handler_active = 1'b0;
        tick();
        drain_check();
    endtask

    initial begin
        int c, n, a, s, e;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        chk("rst_violation", int'(violation), 0);
        chk("rst_violation_addr", int'(violation_addr), 0);
        chk("rst_empty", int'(stack_empty), 1);
        chk("rst_full", int'(stack_full), 0);
        chk("rst_overflow", int'(overflow), 0);

        // Basic hit on top entry, then three-entry miss
        do_push(16'h0100); do_push(16'h0200);
        do_scan(16'h01F0, 16'h0210, 0);
        do_push(16'h0300);
        do_scan(16'h0400, 16'h0500, 0);

        // Range end grows across cycles, restarting each time
        do_sreset();
        do_push(16'h0100);
        blk_wr_start = 16'h00F0; blk_wr_end = 16'h00F8;
        blk_write_active = 1'b1;
        c = cyc;
        exp_addr.push_back(16'h0100);
        exp_cyc.push_back(c + 4);
        tick(); blk_wr_end = 16'h00FA;
        tick(); blk_wr_end = 16'h0102;
        wait_ack();
        blk_write_active = 1'b0;
        repeat (2) tick();
        drain_check();

        // Fill, overflow, exception suppress and abort
        do_sreset();
        for (int i = 1; i <= DEPTH; i++) do_push(AB'(i * 16));
        chk("fill_full", int'(stack_full), 1);
        chk("fill_no_overflow", int'(overflow), 0);
        do_push(16'h0090);
        chk("overflow_set", int'(overflow), 1);
        chk("overflow_full", int'(stack_full), 1);
        do_scan(16'h0080, 16'h0081, 0);
        do_scan(16'h0090, 16'h0091, 0);
        do_scan(16'h0010, 16'h0011, 0);
        do_scan(16'h0080, 16'h0081, 1);
        do_scan(16'h0020, 16'h0021, 2);

        // Pop on empty, push+pop replace
        do_sreset();
        do_pop();
        chk("pop_empty_still_empty", int'(stack_empty), 1);
        chk("pop_empty_not_full", int'(stack_full), 0);
        do_push(16'hAAAA);
        pop_en = 1'b1; push_en = 1'b1; push_addr = 16'hBBBB;
        tick();
        pop_en = 1'b0; push_en = 1'b0;
        mdl[mdl.size()-1] = 16'hBBBB;
        chk("replace_not_empty", int'(stack_empty), 0);
        do_scan(16'hAAAA, 16'hAAAB, 0);
        do_scan(16'hBBBB, 16'hBBBC, 0);
        do_pop();
        chk("replace_count_one", int'(stack_empty), 1);

        // sync_reset while holding a violation
        do_push(16'h0500);
        blk_wr_start = 16'h0500; blk_wr_end = 16'h0501;
        blk_write_active = 1'b1;
        c = cyc;
        exp_addr.push_back(16'h0500);
        exp_cyc.push_back(c + 2);
        for (int i = 0; i < 8 && !violation; i++) tick();
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        mdl.delete();
        chk("sreset_violation", int'(violation), 0);
        chk("sreset_empty", int'(stack_empty), 1);
        chk("sreset_violation_addr", int'(violation_addr), 0);
        blk_write_active = 1'b0;
        repeat (2) tick();
        drain_check();

        // Randomized stacks and ranges
        for (int it = 0; it < 40; it++) begin
            do_sreset();
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) do_push(AB'($urandom_range(0, 16'hFFFF)));
            chk("rand_full", int'(stack_full), int'(n == DEPTH));
            for (int p = $urandom_range(0, 2); p > 0 && mdl.size() > 1; p--) do_pop();
            a = int'(mdl[$urandom_range(0, mdl.size() - 1)]);
            case ($urandom_range(0, 3))
                0: begin s = a; e = a - $urandom_range(0, 3); end
                1: begin s = $urandom_range(0, 16'hFFFF); e = $urandom_range(0, 16'hFFFF); end
                default: begin
                    s = a - $urandom_range(0, 4); if (s < 0) s = 0;
                    e = a + 1 + $urandom_range(0, 4); if (e > 16'hFFFF) e = 16'hFFFF;
                end
            endcase
            if (e < 0) e = 0;
            do_scan(AB'(s), AB'(e), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
